// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// helpers that derive shift-amount widths and level partitioning from WIDTH.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LSHR = 2'd0,
        MODE_ASHR = 2'd1,
        MODE_SHL  = 2'd2,
        MODE_ROTR = 2'd3
    } shift_mode_e;

    // Number of log-shifter levels needed for a given data width: ceil(log2(width)).
    function automatic int shamt_bits(input int width);
        return (width <= 1) ? 0 : $clog2(width);
    endfunction

    // Width of the carried shift-amount field; never zero so ports stay legal at WIDTH=1.
    function automatic int amt_width(input int width);
        return (shamt_bits(width) > 0) ? shamt_bits(width) : 1;
    endfunction

    // First log-shifter level owned by a stage; levels are spread evenly over the stages.
    function automatic int level_lo(input int stage, input int levels, input int stages);
        return (stage * levels) / stages;
    endfunction

    localparam int DEFAULT_WIDTH = 16;
    localparam int SHAMT_BITS    = shamt_bits(DEFAULT_WIDTH);

endpackage

// File: rtl/shifter_stage.sv
// One registered slice of the log shifter: applies levels [LO, HI) of the
// shift, then captures data, valid, overflow, mode and the residual amount.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 4,
    parameter int LO    = 0,
    parameter int HI    = 0
) (
    input  logic              CLK,
    input  logic              ASYNCRESET,
    input  logic              adv,
    input  logic              in_valid,
    input  logic              in_ovf,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [AW-1:0]     in_amt,
    input  shift_mode_e       in_mode,
    output logic              out_valid,
    output logic              out_ovf,
    output logic [WIDTH-1:0]  out_data,
    output logic [AW-1:0]     out_amt,
    output shift_mode_e       out_mode
);

    logic [WIDTH-1:0] shifted;

    // Apply this stage's power-of-two shift levels selected by the residual amount bits.
    always_comb begin
        // NOTE: default assignment first so every path assigns shifted; no latch is inferred.
        shifted = in_data;
        for (int k = LO; k < HI; k++) begin
            if (in_amt[k]) begin
                case (in_mode)
                    MODE_LSHR: shifted = shifted >> (1 << k);
                    MODE_ASHR: shifted = $signed(shifted) >>> (1 << k);
                    MODE_SHL:  shifted = shifted << (1 << k);
                    default:   shifted = (shifted >> (1 << k)) | (shifted << (WIDTH - (1 << k)));
                endcase
            end
        end
    end

    // Stage register: loads everything when the pipeline advances, otherwise holds.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            // NOTE: data registers are cleared too, so out reads 0 while reset is asserted.
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_mode  <= MODE_LSHR;
        end else if (adv) begin
            // NOTE: non-blocking assignments for state so all stages update from pre-edge values.
            out_valid <= in_valid;
            out_ovf   <= in_ovf;
            out_data  <= shifted;
            out_amt   <= in_amt;
            out_mode  <= in_mode;
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (lshr/ashr/shl/rotr) with valid/ready handshakes.
// Out-of-range amounts are resolved before the first register, so later
// stages only ever see an in-range residual amount.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic              CLK,
    input  logic              ASYNCRESET,
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int SB = shamt_bits(WIDTH);
    localparam int AW = amt_width(WIDTH);
    localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

    // Stage chain: index 0 is the pre-register front end, index s+1 is the output of stage s.
    logic              v_c   [STAGES+1];
    logic              ovf_c [STAGES+1];
    logic [WIDTH-1:0]  d_c   [STAGES+1];
    logic [AW-1:0]     a_c   [STAGES+1];
    shift_mode_e       m_c   [STAGES+1];

    logic              adv;
    logic [WIDTH:0]    in1_ext;
    logic              over;
    logic [WIDTH-1:0]  p_data;
    logic [AW-1:0]     p_amt;

    // Whole pipeline moves together whenever the output slot is free or being consumed.
    assign adv      = out_ready | ~v_c[STAGES];
    assign in_ready = adv;

    // Front end: detect overflow and fold out-of-range shifts into pre-filled data with zero residual.
    always_comb begin
        in1_ext = {1'b0, in1};
        over    = (in1_ext >= WIDTH_EXT);
        // Rotation uses the amount modulo WIDTH; WIDTH is a constant so this is a fixed divider.
        p_amt   = AW'(in1_ext % WIDTH_EXT);
        p_data  = in0;
        if (over && (mode != MODE_ROTR)) begin
            p_amt  = '0;
            p_data = (mode == MODE_ASHR) ? {WIDTH{in0[WIDTH-1]}} : '0;
        end
    end

    assign v_c[0]   = in_valid;
    assign ovf_c[0] = in_valid & over;
    assign d_c[0]   = p_data;
    assign a_c[0]   = p_amt;
    assign m_c[0]   = shift_mode_e'(mode);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .LO    (level_lo(s, SB, STAGES)),
            .HI    (level_lo(s + 1, SB, STAGES))
        ) u_stage (
            .CLK        (CLK),
            .ASYNCRESET (ASYNCRESET),
            .adv        (adv),
            .in_valid   (v_c[s]),
            .in_ovf     (ovf_c[s]),
            .in_data    (d_c[s]),
            .in_amt     (a_c[s]),
            .in_mode    (m_c[s]),
            .out_valid  (v_c[s+1]),
            .out_ovf    (ovf_c[s+1]),
            .out_data   (d_c[s+1]),
            .out_amt    (a_c[s+1]),
            .out_mode   (m_c[s+1])
        );
    end

    assign out       = d_c[STAGES];
    assign out_valid = v_c[STAGES];
    assign overflow  = ovf_c[STAGES];

endmodule
